// File: rtl/mem_port_arbiter_if.sv
// Bundle of the three requester ports, the hold control, the per-port
// completion signals and the single-port memory bus.
// "master" is the environment side (requesters plus memory);
// "slave" is the arbiter side.
interface mem_port_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  logic [2:0]      req;
  logic [2:0]      we;
  logic [3*AW-1:0] addr;
  logic [3*DW-1:0] wdata;
  logic            hold;
  logic [2:0]      ack;
  logic [DW-1:0]   rdata;
  logic [1:0]      owner;
  logic            busy;
  logic            mem_en;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;

  modport master (
    output req, we, addr, wdata, hold, mem_rdata,
    input  ack, rdata, owner, busy, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  req, we, addr, wdata, hold, mem_rdata,
    output ack, rdata, owner, busy, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Three-port arbiter in front of a single-port memory with a fixed read
// latency. Port 2 (loader/debug) has absolute priority; ports 0 (fetch)
// and 1 (data) share round-robin. One transaction is outstanding at a time:
// IDLE -> ISSUE (1 cycle) -> WAIT (MEM_LAT cycles) -> RESP (1 cycle).
// Outputs decode only state and latched registers, so there is no
// combinational path from req, hold or mem_rdata to any output.
module mem_port_arbiter #(
  parameter int AW      = 10,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);

  if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_mem_lat
    $error("mem_port_arbiter: MEM_LAT must be within 1..4");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    owner_q, owner_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [1:0]    cnt_q, cnt_d;
  // Index (0 or 1) of the port last granted among ports 0/1; that port
  // loses the next tie.
  logic          last_q, last_d;

  logic [2:0]    elig_s;
  logic          grant_s;
  logic [1:0]    win_s;

  // Eligibility and priority selection of the winning port for this cycle.
  always_comb begin
    elig_s  = {bus.req[2], bus.req[1] & ~bus.hold, bus.req[0] & ~bus.hold};
    grant_s = 1'b1;
    win_s   = 2'd0;
    if (elig_s[2]) begin
      win_s = 2'd2;
    end else if (elig_s[1] && elig_s[0]) begin
      win_s = {1'b0, ~last_q};
    end else if (elig_s[1]) begin
      win_s = 2'd1;
    end else if (elig_s[0]) begin
      win_s = 2'd0;
    end else begin
      grant_s = 1'b0;
      win_s   = 2'd0;
    end
  end

  // Next-state logic: grant latch, latency countdown and read-data capture.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_s) begin
          state_d = ST_ISSUE;
          owner_d = win_s;
          we_d    = bus.we[win_s];
          addr_d  = bus.addr[win_s*AW +: AW];
          wdata_d = bus.wdata[win_s*DW +: DW];
          // Port 2 grants leave the 0/1 round-robin pointer alone.
          if (win_s != 2'd2) begin
            last_d = win_s[0];
          end else begin
            last_d = last_q;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        cnt_d   = 2'(MEM_LAT - 1);
      end
      ST_WAIT: begin
        if (cnt_q == 2'd0) begin
          state_d = ST_RESP;
          if (!we_q) begin
            rdata_d = bus.mem_rdata;
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and latched-transaction registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= 2'b11;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= 2'd0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  // Output decode from state and latched registers only.
  always_comb begin
    bus.mem_en    = (state_q == ST_ISSUE);
    bus.mem_we    = (state_q == ST_ISSUE) & we_q;
    bus.mem_addr  = addr_q;
    bus.mem_wdata = wdata_q;
    bus.rdata     = rdata_q;
    bus.busy      = (state_q != ST_IDLE);
    if (state_q == ST_IDLE) begin
      bus.owner = 2'b11;
    end else begin
      bus.owner = owner_q;
    end
    if (state_q == ST_RESP) begin
      bus.ack = 3'b001 << owner_q;
    end else begin
      bus.ack = 3'b000;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with MEM_LAT=2. A small memory model
// returns read data exactly MEM_LAT cycles after the mem_en cycle and a
// poison value in every other cycle, so that mistimed capture is visible.
module tb_mem_port_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int MEM_LAT = 2;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(MEM_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory content: fixed pattern, address 5 holds 0x12345678.
  function automatic logic [31:0] mem_pat(input logic [9:0] a);
    if (a == 10'h005) return 32'h1234_5678;
    return 32'hA5A5_0000 | {22'd0, a};
  endfunction

  // Memory model: two-stage read pipeline plus one remembered write.
  logic [31:0] pipe_d0, pipe_d1;
  logic [1:0]  pipe_v;
  logic        wr_v;
  logic [9:0]  wr_a;
  logic [31:0] wr_dat;

  always @(posedge clk) begin
    pipe_v  <= {pipe_v[0], bus.mem_en & ~bus.mem_we};
    pipe_d1 <= pipe_d0;
    pipe_d0 <= (wr_v && wr_a == bus.mem_addr) ? wr_dat : mem_pat(bus.mem_addr);
    if (bus.mem_en && bus.mem_we) begin
      wr_v   <= 1'b1;
      wr_a   <= bus.mem_addr;
      wr_dat <= bus.mem_wdata;
    end else if (!rst_n) begin
      wr_v <= 1'b0;
    end
  end

  assign bus.mem_rdata = pipe_v[1] ? pipe_d1 : 32'hBAD0_BAD0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic w, input logic [9:0] a, input logic [31:0] d);
    bus.we[p] = w;
    bus.addr[p*AW +: AW] = a;
    bus.wdata[p*DW +: DW] = d;
  endtask

  // One isolated transaction from IDLE; req optionally held for one cycle only.
  task automatic txn(input string tag, input int p, input logic w, input logic [9:0] a,
                     input logic [31:0] d, input logic [31:0] exp_rd, input logic drop_early);
    set_port(p, w, a, d);
    bus.req[p] = 1'b1;
    step();
    check_val({tag, "_mem_en"}, bus.mem_en, 1'b1);
    check_val({tag, "_mem_we"}, bus.mem_we, w);
    check_val({tag, "_mem_addr"}, bus.mem_addr, a);
    check_val({tag, "_owner"}, bus.owner, p[1:0]);
    if (w) check_val({tag, "_mem_wdata"}, bus.mem_wdata, d);
    if (drop_early) bus.req[p] = 1'b0;
    step();
    check_val({tag, "_wait_en"}, bus.mem_en, 1'b0);
    check_val({tag, "_wait_busy"}, bus.busy, 1'b1);
    check_val({tag, "_wait_ack"}, bus.ack, 3'b000);
    step();
    step();
    check_val({tag, "_ack"}, bus.ack, 3'b001 << p);
    check_val({tag, "_rdata"}, bus.rdata, exp_rd);
    bus.req[p] = 1'b0;
    step();
    check_val({tag, "_idle_busy"}, bus.busy, 1'b0);
    check_val({tag, "_idle_owner"}, bus.owner, 2'b11);
    check_val({tag, "_idle_ack"}, bus.ack, 3'b000);
  endtask

  initial begin
    int seq [7];
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    bus.req   = 3'b000;
    bus.we    = 3'b000;
    bus.addr  = '0;
    bus.wdata = '0;
    bus.hold  = 1'b0;
    step();
    step();

    // Reset state
    check_val("rst_busy", bus.busy, 1'b0);
    check_val("rst_owner", bus.owner, 2'b11);
    check_val("rst_ack", bus.ack, 3'b000);
    check_val("rst_mem_en", bus.mem_en, 1'b0);
    check_val("rst_mem_we", bus.mem_we, 1'b0);
    check_val("rst_rdata", bus.rdata, 32'h0);
    check_val("rst_mem_addr", bus.mem_addr, 10'h0);
    check_val("rst_mem_wdata", bus.mem_wdata, 32'h0);
    rst_n = 1'b1;
    step();

    // Read, write, read-back, early-drop read
    txn("rd0", 0, 1'b0, 10'h005, 32'h0, 32'h1234_5678, 1'b0);
    txn("wr1", 1, 1'b1, 10'h3FF, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
    txn("rb0", 0, 1'b0, 10'h3FF, 32'h0, 32'hDEAD_BEEF, 1'b0);
    txn("drop1", 1, 1'b0, 10'h007, 32'h0, 32'hA5A5_0007, 1'b1);

    // Contention from reset: 2,2,2 then 1,0,1,0 after req[2] drops
    rst_n = 1'b0;
    bus.req = 3'b000;
    step();
    set_port(0, 1'b0, 10'h010, 32'h0);
    set_port(1, 1'b0, 10'h011, 32'h0);
    set_port(2, 1'b0, 10'h012, 32'h0);
    rst_n = 1'b1;
    bus.req = 3'b111;
    step();
    seq = '{2, 2, 2, 1, 0, 1, 0};
    for (int k = 0; k < 7; k++) begin
      check_val($sformatf("cont%0d_owner", k), bus.owner, seq[k]);
      check_val($sformatf("cont%0d_mem_en", k), bus.mem_en, 1'b1);
      check_val($sformatf("cont%0d_mem_addr", k), bus.mem_addr, 10'h010 + seq[k]);
      step();
      step();
      step();
      check_val($sformatf("cont%0d_ack", k), bus.ack, 3'b001 << seq[k]);
      check_val($sformatf("cont%0d_rdata", k), bus.rdata, 32'hA5A5_0010 + seq[k]);
      if (k == 2) bus.req = 3'b011;
      if (k == 6) bus.req = 3'b000;
      step();
      step();
    end

    // Hold: ports 0/1 blocked, port 2 still served
    bus.hold = 1'b1;
    bus.req = 3'b011;
    for (int k = 0; k < 10; k++) begin
      step();
      check_val($sformatf("hold%0d_mem_en", k), bus.mem_en, 1'b0);
      check_val($sformatf("hold%0d_busy", k), bus.busy, 1'b0);
    end
    bus.req = 3'b111;
    step();
    check_val("hold_p2_owner", bus.owner, 2'd2);
    check_val("hold_p2_mem_en", bus.mem_en, 1'b1);
    step();
    step();
    step();
    check_val("hold_p2_ack", bus.ack, 3'b100);
    bus.req = 3'b011;
    bus.hold = 1'b0;
    step();
    step();
    check_val("unhold_p1_owner", bus.owner, 2'd1);
    step();
    step();
    step();
    check_val("unhold_p1_ack", bus.ack, 3'b010);
    step();
    step();
    check_val("unhold_p0_owner", bus.owner, 2'd0);
    bus.hold = 1'b1;
    step();
    step();
    step();
    check_val("hold_mid_p0_ack", bus.ack, 3'b001);
    bus.req = 3'b000;
    bus.hold = 1'b0;
    step();
    step();

    // Reset during WAIT of a port 0 read
    set_port(0, 1'b0, 10'h005, 32'h0);
    bus.req = 3'b001;
    step();
    step();
    rst_n = 1'b0;
    step();
    check_val("rmid_busy", bus.busy, 1'b0);
    check_val("rmid_owner", bus.owner, 2'b11);
    check_val("rmid_ack", bus.ack, 3'b000);
    check_val("rmid_rdata", bus.rdata, 32'h0);
    rst_n = 1'b1;
    step();
    check_val("rmid_new_mem_en", bus.mem_en, 1'b1);
    check_val("rmid_new_owner", bus.owner, 2'd0);
    check_val("rmid_late_rdata", bus.rdata, 32'h0);
    step();
    check_val("rmid_no_ack2", bus.ack, 3'b000);
    step();
    check_val("rmid_no_ack3", bus.ack, 3'b000);
    step();
    check_val("rmid_ack", bus.ack, 3'b001);
    check_val("rmid_new_rdata", bus.rdata, 32'h1234_5678);
    bus.req = 3'b000;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
